// File: rtl/lcd_timer_pkg.sv
// Shared definitions for the LCD interval timer: FSM encoding, default sizing
// and the standard LCD sequencing waits expressed in 1 us base ticks.
package lcd_timer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } timer_state_e;

  localparam int unsigned DEF_CNT_WIDTH      = 16;
  localparam int unsigned DEF_PRESCALE_DIV   = 50;
  localparam int unsigned DEF_PRESCALE_WIDTH = 6;

  // LCD controller waits, in 1 us ticks at the default prescale
  localparam int unsigned T_POWERUP_15MS = 15000;
  localparam int unsigned T_WAIT_4MS1    = 4100;
  localparam int unsigned T_WAIT_100US   = 100;
  localparam int unsigned T_WAIT_40US    = 40;

endpackage

// File: rtl/lcd_interval_timer_if.sv
// Control/status bundle between the LCD command FSM (master) and the
// interval timer (slave).
interface lcd_interval_timer_if #(
  parameter int unsigned CNT_WIDTH = lcd_timer_pkg::DEF_CNT_WIDTH
);
  logic                 EnableCount;
  logic                 DisableCount;
  logic                 Periodic;
  logic [CNT_WIDTH-1:0] Interval;
  logic                 TimerIndicator;
  logic                 Busy;
  logic [CNT_WIDTH-1:0] Remaining;

  modport master (
    output EnableCount, DisableCount, Periodic, Interval,
    input  TimerIndicator, Busy, Remaining
  );

  modport slave (
    input  EnableCount, DisableCount, Periodic, Interval,
    output TimerIndicator, Busy, Remaining
  );
endinterface

// File: rtl/lcd_prescaler.sv
// Clock divider producing a one-cycle base tick every DIV enabled cycles,
// with a synchronous clear that restarts the phase at zero.
module lcd_prescaler
  import lcd_timer_pkg::*;
#(
  parameter int unsigned DIV   = DEF_PRESCALE_DIV,
  parameter int unsigned WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV - 1);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + WIDTH'(1);
    end
  end

  // Tick marks the edge on which the counter wraps, so it stays live during clear
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/lcd_interval_timer.sv
// Programmable one-shot/periodic interval timer for LCD sequencing; emits a
// single-cycle TimerIndicator after Interval base ticks.
module lcd_interval_timer
  import lcd_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned PRESCALE_DIV   = DEF_PRESCALE_DIV,
  parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input logic           clock,
  input logic           rst,
  lcd_interval_timer_if.slave tif
);
  timer_state_e         state;
  logic                 periodic_q;
  logic [CNT_WIDTH-1:0] interval_q;
  logic [CNT_WIDTH-1:0] remaining_q;
  logic                 ind_q;
  logic                 busy_q;

  logic start_ok;
  logic tick;
  logic terminal;
  logic pre_clear;

  assign start_ok  = tif.EnableCount && (tif.Interval != '0);
  assign terminal  = tick && (remaining_q == CNT_WIDTH'(1));
  assign pre_clear = tif.DisableCount || start_ok || (state == IDLE);

  lcd_prescaler #(
    .DIV   (PRESCALE_DIV),
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock  (clock),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (state == COUNT),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      periodic_q  <= 1'b0;
      interval_q  <= '0;
      remaining_q <= '0;
      ind_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (tif.DisableCount) begin
      state       <= IDLE;
      periodic_q  <= 1'b0;
      interval_q  <= '0;
      remaining_q <= '0;
      ind_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // tick is only raised in COUNT, so terminal implies COUNT
      ind_q <= terminal;
      if (tick) begin
        if (terminal) begin
          if (periodic_q) begin
            remaining_q <= interval_q;
          end else begin
            remaining_q <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end else begin
          remaining_q <= remaining_q - CNT_WIDTH'(1);
        end
      end
      // Start/retrigger is written last so it overrides reload or return to IDLE
      if (start_ok) begin
        state       <= COUNT;
        busy_q      <= 1'b1;
        remaining_q <= tif.Interval;
        interval_q  <= tif.Interval;
        periodic_q  <= tif.Periodic;
      end
    end
  end

  assign tif.TimerIndicator = ind_q;
  assign tif.Busy           = busy_q;
  assign tif.Remaining      = remaining_q;

endmodule

// File: tb/tb_lcd_interval_timer.sv
// Self-checking bench for lcd_interval_timer: vector table, directed corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_lcd_interval_timer;
  localparam int unsigned CW = 16;
  localparam int unsigned P  = 4;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  lcd_interval_timer_if #(.CNT_WIDTH(CW)) bus ();
  lcd_interval_timer_if #(.CNT_WIDTH(CW)) bus1 ();

  lcd_interval_timer #(.CNT_WIDTH(CW), .PRESCALE_DIV(P), .PRESCALE_WIDTH(2)) dut (
    .clock (clock),
    .rst   (rst),
    .tif   (bus)
  );

  lcd_interval_timer #(.CNT_WIDTH(CW), .PRESCALE_DIV(1), .PRESCALE_WIDTH(1)) dut1 (
    .clock (clock),
    .rst   (rst),
    .tif   (bus1)
  );

  typedef struct {
    bit          en;
    bit          dis;
    bit          per;
    int unsigned iv;
    bit          ind;
    bit          busy;
    int unsigned rem;
  } vec_t;

  vec_t tbl[14];

  int n_vec = 0;
  int n_err = 0;

  // Model: an active timer is a start edge plus interval; everything else is
  // derived from the elapsed edge count.
  longint      e = 0;
  longint      m_s = 0;
  int unsigned m_n = 0;
  bit          m_act = 1'b0;
  bit          m_per = 1'b0;
  bit          last_ind;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e - 1);
    end
  endtask

  task automatic drive(input bit en, input bit dis, input bit per, input int unsigned iv);
    bus.EnableCount  = en;
    bus.DisableCount = dis;
    bus.Periodic     = per;
    bus.Interval     = CW'(iv);
  endtask

  task automatic step(input bit chk);
    bit          p;
    longint      d;
    longint      r;
    longint      rem;
    longint      len;
    p = 1'b0;
    if (bus.DisableCount) begin
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        d   = e - m_s;
        len = longint'(m_n) * P;
        if (d % len == 0) begin
          p = 1'b1;
          if (!m_per) m_act = 1'b0;
        end
      end
      if (bus.EnableCount && bus.Interval != 0) begin
        m_act = 1'b1;
        m_s   = e;
        m_n   = bus.Interval;
        m_per = bus.Periodic;
      end
    end
    rem = 0;
    if (m_act) begin
      d   = e - m_s;
      len = longint'(m_n) * P;
      r   = d % len;
      rem = (r == 0) ? m_n : m_n - r / P;
    end
    @(posedge clock);
    #1;
    e++;
    last_ind = bus.TimerIndicator;
    if (chk) begin
      check("model_pulse", bus.TimerIndicator, p);
      check("model_busy", bus.Busy, m_act);
      check("model_remaining", bus.Remaining, rem);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    longint s0;
    longint rel;
    int     np;
    longint pe;

    drive(0, 0, 0, 0);
    bus1.EnableCount  = 1'b0;
    bus1.DisableCount = 1'b0;
    bus1.Periodic     = 1'b0;
    bus1.Interval     = '0;

    tbl = '{
      '{1, 0, 0, 3, 0, 1, 3},
      '{0, 0, 0, 0, 0, 1, 3}, '{0, 0, 0, 0, 0, 1, 3}, '{0, 0, 0, 0, 0, 1, 3},
      '{0, 0, 0, 0, 0, 1, 2}, '{0, 0, 0, 0, 0, 1, 2}, '{0, 0, 0, 0, 0, 1, 2},
      '{0, 0, 0, 0, 0, 1, 2},
      '{0, 0, 0, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 1, 1},
      '{0, 0, 0, 0, 0, 1, 1},
      '{0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0}
    };

    // Reset state
    drive(1, 0, 1, 5);
    repeat (2) @(posedge clock);
    #1;
    check("reset_ind", bus.TimerIndicator, 0);
    check("reset_busy", bus.Busy, 0);
    check("reset_remaining", bus.Remaining, 0);
    drive(0, 0, 0, 0);
    rst = 1'b1;

    // One-shot, Interval=3: pulse at edge 12
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].dis, tbl[i].per, tbl[i].iv);
      step(0);
      check("tbl_ind", bus.TimerIndicator, tbl[i].ind);
      check("tbl_busy", bus.Busy, tbl[i].busy);
      check("tbl_remaining", bus.Remaining, tbl[i].rem);
    end
    drive(0, 0, 0, 0);

    // Periodic, Interval=3: pulses at 12, 24, 36 relative to start
    drive(1, 0, 1, 3);
    s0 = e;
    step(1);
    drive(0, 0, 0, 0);
    np = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (last_ind) begin
        check("periodic_pulse_edge", e - 1 - s0, 12 * (np + 1));
        np++;
      end
    end
    check("periodic_pulse_count", np, 3);
    drive(0, 1, 0, 0);
    step(1);
    drive(0, 0, 0, 0);

    // Abort at edge 10 of a periodic count: no pulse at 12
    drive(1, 0, 1, 3);
    step(1);
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(1);
    drive(0, 1, 0, 0);
    step(1);
    drive(0, 0, 0, 0);
    check("abort_busy", bus.Busy, 0);
    check("abort_remaining", bus.Remaining, 0);
    np = 0;
    for (int i = 11; i <= 16; i++) begin
      step(1);
      if (last_ind) np++;
    end
    check("abort_no_pulse", np, 0);

    // Retrigger at edge 8 with Interval=5: only pulse at 28
    drive(1, 0, 0, 3);
    s0 = e;
    step(1);
    drive(0, 0, 0, 0);
    np = 0;
    pe = -1;
    for (int i = 1; i <= 32; i++) begin
      rel = e - s0;
      if (rel == 8) drive(1, 0, 0, 5);
      step(1);
      drive(0, 0, 0, 0);
      if (last_ind) begin
        np++;
        pe = e - 1 - s0;
      end
    end
    check("retrigger_pulse_count", np, 1);
    check("retrigger_pulse_edge", pe, 28);

    // Interval=0 is rejected in IDLE
    drive(1, 0, 1, 0);
    step(1);
    check("zero_interval_busy", bus.Busy, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1);

    // Asynchronous reset mid-count, between edges
    drive(1, 0, 1, 2);
    step(1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1);
    rst = 1'b0;
    #2;
    check("async_rst_busy", bus.Busy, 0);
    check("async_rst_remaining", bus.Remaining, 0);
    check("async_rst_ind", bus.TimerIndicator, 0);
    m_act = 1'b0;
    rst = 1'b1;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (last_ind) np++;
    end
    check("async_rst_no_pulse", np, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 6));
      step(1);
    end
    drive(0, 1, 0, 0);
    step(1);
    drive(0, 0, 0, 0);

    // PRESCALE_DIV=1, Interval=1, periodic: pulse every cycle
    bus1.EnableCount = 1'b1;
    bus1.Periodic    = 1'b1;
    bus1.Interval    = CW'(1);
    @(posedge clock);
    #1;
    bus1.EnableCount = 1'b0;
    bus1.Interval    = '0;
    check("div1_start_busy", bus1.Busy, 1);
    check("div1_start_remaining", bus1.Remaining, 1);
    check("div1_start_ind", bus1.TimerIndicator, 0);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock);
      #1;
      check("div1_ind", bus1.TimerIndicator, 1);
      check("div1_remaining", bus1.Remaining, 1);
      check("div1_busy", bus1.Busy, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
